csr_req_router: RTL and testbench
=================================

Name: csr_req_router

Overview:
- Sequenced replacement for combinational CSR demuxing.
- Routes one core CSR request stream to NumPorts accelerator CSR ports, selected by address window; strips the window base from the address.
- Tracks outstanding reads in an in-order tag FIFO so each read response returns from the port that received that read. No fixed-priority response muxing.
- Sits between the core CSR interface and the accelerator CSR managers.

Parameters:
- NumPorts, 2, number of accelerator CSR ports (>=1).
- RegsPerPort, 8, CSR window size per port; must be a power of two.
- RegDataWidth, 32, CSR data width.
- MaxOutstanding, 2, depth of the read tag FIFO (>=1).
- AddrWidth, $clog2(NumPorts*RegsPerPort)+1, core address width; the extra MSB lets unmapped addresses be expressed.
- PortAddrWidth, $clog2(RegsPerPort), accelerator address width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- csr_req_addr_i  in  AddrWidth  core request address.
- csr_req_data_i  in  RegDataWidth  write data.
- csr_req_wen_i  in  1  1=write, 0=read.
- csr_req_valid_i  in  1  request valid.
- csr_req_ready_o  out  1  request ready.
- csr_rsp_data_o  out  RegDataWidth  read data.
- csr_rsp_valid_o  out  1  response valid.
- csr_rsp_ready_i  in  1  response ready.
- acc_csr_req_addr_o  out  [NumPorts][PortAddrWidth]  local address.
- acc_csr_req_data_o  out  [NumPorts][RegDataWidth]  write data.
- acc_csr_req_wen_o  out  [NumPorts]  write enable.
- acc_csr_req_valid_o  out  [NumPorts]  request valid.
- acc_csr_req_ready_i  in  [NumPorts]  request ready.
- acc_csr_rsp_data_i  in  [NumPorts][RegDataWidth]  read data.
- acc_csr_rsp_valid_i  in  [NumPorts]  response valid.
- acc_csr_rsp_ready_o  out  [NumPorts]  response ready.
- outstanding_o  out  $clog2(MaxOutstanding+1)  reads in flight.

Behaviour:
- Clock and reset: single clock clk_i; reset rst_ni is synchronous, active-low. Reset empties the tag FIFO and clears outstanding_o.
- Outputs during and after reset: every acc_*_valid_o and csr_rsp_valid_o is 0. csr_req_ready_o is 0 while rst_ni=0.
- Decode:
  - port = addr / RegsPerPort; local address = addr % RegsPerPort.
  - port >= NumPorts is "unmapped": tag value NumPorts.
- Request path (combinational, zero latency):
  - Only the selected port sees valid/addr/data/wen; all other ports are driven 0.
  - Handshake fires when valid_i && ready_o.
- csr_req_ready_o:
  - Mapped write: acc_csr_req_ready_i[port].
  - Mapped read: acc_csr_req_ready_i[port] && !fifo_full.
  - Unmapped write: 1 (request dropped).
  - Unmapped read: !fifo_full.
- Read tracking:
  - Each accepted read pushes its tag.
  - Writes produce no response and push nothing.
  - Full FIFO blocks reads even if a pop occurs in the same cycle. No bypass; this keeps the ready path free of rsp_ready.
- Response path, driven from the FIFO head:
  - Empty FIFO: csr_rsp_valid_o=0 and all acc_csr_rsp_ready_o=0.
  - Head = mapped port p: csr_rsp_valid_o = acc_csr_rsp_valid_i[p]; data from port p; acc_csr_rsp_ready_o[p] = csr_rsp_ready_i; all other ports' ready = 0.
  - Head = unmapped: csr_rsp_valid_o=1 and data='0 from the cycle after the push.
  - Pop on csr_rsp_valid_o && csr_rsp_ready_i.
  - A response valid from a non-head port is stalled (ready held 0), never dropped.
- Simultaneous push and pop: pointers both advance; outstanding_o is unchanged.
- Pointer wrap: modulo MaxOutstanding; full/empty are derived from a count, not from pointer equality.
- outstanding_o equals the FIFO count, registered.
- Reset mid-operation: in-flight tags are discarded. Accelerators are reset in the same domain; stale responses after reset are outside scope.
- Assertions:
  - No pop when empty.
  - No push when full.
  - Decoded port < NumPorts or tagged unmapped.

Decomposition:
- Package csr_router_pkg holds the tag-width function tag_w(NumPorts) = $clog2(NumPorts+1) and the UnmappedRspData constant ('0).
- One sub-module, csr_tag_fifo: synchronous FIFO with parameters Depth and Width; signals push/pop/full/empty/count and head data.
- Top level holds decode, request demux and response mux.

Test Plan:
- Write addr 10 with data 0xA5A5A5A5, port1 ready -> acc_csr_req_valid_o[1]=1, addr=2, data=0xA5A5A5A5, port0 valid=0; no response; outstanding_o stays 0.
- Read addr 3 then read addr 9 back-to-back; port1 raises rsp valid (0x22) first, port0 raises rsp valid (0x11) two cycles later -> core sees 0x11 then 0x22; port1 rsp_ready held 0 until the port0 response pops.
- Three reads with MaxOutstanding=2 and csr_rsp_ready_i=0 -> third read sees csr_req_ready_o=0; outstanding_o=2; the read is accepted the cycle after the first response pops.
- Read addr 20 (unmapped) -> accepted; next cycle csr_rsp_valid_o=1 with data 0; write addr 20 -> accepted with no acc valid and no response.
- Push and pop in the same cycle at count=1 -> outstanding_o stays 1; head advances correctly across pointer wrap over 10 reads.
- rst_ni=0 for one cycle with 2 reads outstanding -> outstanding_o=0, csr_rsp_valid_o=0, all acc rsp_ready=0 next cycle; a new read then completes normally.

Source files
------------

// File: rtl/csr_router_pkg.sv
// Shared types and helpers for the CSR request router: tag sizing and the
// data returned for reads to unmapped addresses.
package csr_router_pkg;

    // Tags 0..NumPorts-1 name a port; NumPorts itself marks an unmapped read.
    function automatic int tag_w(input int num_ports);
        return $clog2(num_ports + 1);
    endfunction

    localparam logic [63:0] UnmappedRspData = '0;

endpackage

// File: rtl/csr_req_router_if.sv
// Core-side and accelerator-side CSR bus bundle for csr_req_router.
// Suffixes _i/_o are from the router's point of view.
interface csr_req_router_if #(
    parameter int NumPorts     = 2,
    parameter int RegsPerPort  = 8,
    parameter int RegDataWidth = 32
);
    localparam int AddrWidth     = $clog2(NumPorts * RegsPerPort) + 1;
    localparam int PortAddrWidth = $clog2(RegsPerPort);

    logic [AddrWidth-1:0]                        csr_req_addr_i;
    logic [RegDataWidth-1:0]                     csr_req_data_i;
    logic                                        csr_req_wen_i;
    logic                                        csr_req_valid_i;
    logic                                        csr_req_ready_o;
    logic [RegDataWidth-1:0]                     csr_rsp_data_o;
    logic                                        csr_rsp_valid_o;
    logic                                        csr_rsp_ready_i;
    logic [NumPorts-1:0][PortAddrWidth-1:0]      acc_csr_req_addr_o;
    logic [NumPorts-1:0][RegDataWidth-1:0]       acc_csr_req_data_o;
    logic [NumPorts-1:0]                         acc_csr_req_wen_o;
    logic [NumPorts-1:0]                         acc_csr_req_valid_o;
    logic [NumPorts-1:0]                         acc_csr_req_ready_i;
    logic [NumPorts-1:0][RegDataWidth-1:0]       acc_csr_rsp_data_i;
    logic [NumPorts-1:0]                         acc_csr_rsp_valid_i;
    logic [NumPorts-1:0]                         acc_csr_rsp_ready_o;

    modport slave (
        input  csr_req_addr_i, csr_req_data_i, csr_req_wen_i, csr_req_valid_i,
               csr_rsp_ready_i, acc_csr_req_ready_i, acc_csr_rsp_data_i,
               acc_csr_rsp_valid_i,
        output csr_req_ready_o, csr_rsp_data_o, csr_rsp_valid_o,
               acc_csr_req_addr_o, acc_csr_req_data_o, acc_csr_req_wen_o,
               acc_csr_req_valid_o, acc_csr_rsp_ready_o
    );

    modport master (
        output csr_req_addr_i, csr_req_data_i, csr_req_wen_i, csr_req_valid_i,
               csr_rsp_ready_i, acc_csr_req_ready_i, acc_csr_rsp_data_i,
               acc_csr_rsp_valid_i,
        input  csr_req_ready_o, csr_rsp_data_o, csr_rsp_valid_o,
               acc_csr_req_addr_o, acc_csr_req_data_o, acc_csr_req_wen_o,
               acc_csr_req_valid_o, acc_csr_rsp_ready_o
    );

endinterface

// File: rtl/csr_tag_fifo.sv
// In-order tag FIFO for outstanding reads. Full/empty come from an explicit
// count so pointer wrap at a non-power-of-two depth is unambiguous.
module csr_tag_fifo #(
    parameter  int Depth = 2,
    parameter  int Width = 2,
    localparam int CntW  = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o,
    output logic [Width-1:0] head_o
);
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_wptr, r_rptr;
    logic [CntW-1:0]  r_count;
    logic [PtrW-1:0]  w_wptr_nxt, w_rptr_nxt;

    assign w_wptr_nxt = (r_wptr == PtrW'(Depth - 1)) ? '0 : r_wptr + 1'b1;
    assign w_rptr_nxt = (r_rptr == PtrW'(Depth - 1)) ? '0 : r_rptr + 1'b1;

    assign full_o  = (r_count == CntW'(Depth));
    assign empty_o = (r_count == '0);
    assign count_o = r_count;
    assign head_o  = r_mem[r_rptr];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (push_i) begin
                r_mem[r_wptr] <= data_i;
                r_wptr        <= w_wptr_nxt;
            end
            if (pop_i) r_rptr <= w_rptr_nxt;
            case ({push_i, pop_i})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(pop_i && empty_o));
            assert (!(push_i && full_o));
        end
    end

endmodule

// File: rtl/csr_req_router.sv
// Routes one core CSR stream to NumPorts accelerator windows; read responses
// are returned strictly in request order by following the tag FIFO head.
module csr_req_router
    import csr_router_pkg::*;
#(
    parameter  int NumPorts       = 2,
    parameter  int RegsPerPort    = 8,
    parameter  int RegDataWidth   = 32,
    parameter  int MaxOutstanding = 2,
    localparam int CntW           = $clog2(MaxOutstanding + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    csr_req_router_if.slave bus,
    output logic [CntW-1:0] outstanding_o
);
    localparam int AddrWidth     = $clog2(NumPorts * RegsPerPort) + 1;
    localparam int PortAddrWidth = $clog2(RegsPerPort);
    localparam int PW            = AddrWidth - PortAddrWidth;
    localparam int TagW          = tag_w(NumPorts);

    logic [PW-1:0]            w_port;
    logic [PortAddrWidth-1:0] w_local;
    logic                     w_mapped;
    logic [TagW-1:0]          w_tag;
    logic                     w_sel_rdy;
    logic                     w_push, w_pop;
    logic                     w_full, w_empty;
    logic [TagW-1:0]          w_head;

    assign w_port   = bus.csr_req_addr_i[AddrWidth-1:PortAddrWidth];
    assign w_local  = bus.csr_req_addr_i[PortAddrWidth-1:0];
    assign w_mapped = (int'(w_port) < NumPorts);
    assign w_tag    = w_mapped ? TagW'(w_port) : TagW'(NumPorts);

    // Request demux: only the decoded port sees the request, others stay at 0.
    always_comb begin
        bus.acc_csr_req_addr_o  = '0;
        bus.acc_csr_req_data_o  = '0;
        bus.acc_csr_req_wen_o   = '0;
        bus.acc_csr_req_valid_o = '0;
        w_sel_rdy               = 1'b0;
        for (int p = 0; p < NumPorts; p++) begin
            if (w_mapped && (w_port == PW'(p))) begin
                bus.acc_csr_req_addr_o[p]  = w_local;
                bus.acc_csr_req_data_o[p]  = bus.csr_req_data_i;
                bus.acc_csr_req_wen_o[p]   = bus.csr_req_wen_i;
                bus.acc_csr_req_valid_o[p] = bus.csr_req_valid_i && rst_ni;
                w_sel_rdy                  = bus.acc_csr_req_ready_i[p];
            end
        end
    end

    // Reads need a free tag slot; a same-cycle pop does not free one.
    always_comb begin
        bus.csr_req_ready_o = 1'b0;
        if (rst_ni) begin
            if (w_mapped)
                bus.csr_req_ready_o = bus.csr_req_wen_i ? w_sel_rdy : (w_sel_rdy && !w_full);
            else
                bus.csr_req_ready_o = bus.csr_req_wen_i ? 1'b1 : !w_full;
        end
    end

    assign w_push = bus.csr_req_valid_i && bus.csr_req_ready_o && !bus.csr_req_wen_i;

    always_comb begin
        bus.csr_rsp_valid_o     = 1'b0;
        bus.csr_rsp_data_o      = '0;
        bus.acc_csr_rsp_ready_o = '0;
        if (rst_ni && !w_empty) begin
            if (w_head == TagW'(NumPorts)) begin
                bus.csr_rsp_valid_o = 1'b1;
                bus.csr_rsp_data_o  = RegDataWidth'(UnmappedRspData);
            end else begin
                for (int p = 0; p < NumPorts; p++) begin
                    if (w_head == TagW'(p)) begin
                        bus.csr_rsp_valid_o        = bus.acc_csr_rsp_valid_i[p];
                        bus.csr_rsp_data_o         = bus.acc_csr_rsp_data_i[p];
                        bus.acc_csr_rsp_ready_o[p] = bus.csr_rsp_ready_i;
                    end
                end
            end
        end
    end

    assign w_pop = bus.csr_rsp_valid_o && bus.csr_rsp_ready_i;

    csr_tag_fifo #(
        .Depth (MaxOutstanding),
        .Width (TagW)
    ) u_tag_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_push),
        .data_i  (w_tag),
        .pop_i   (w_pop),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (outstanding_o),
        .head_o  (w_head)
    );

    always_ff @(posedge clk_i) begin
        if (rst_ni && w_push)
            assert (w_mapped ? (int'(w_tag) < NumPorts) : (w_tag == TagW'(NumPorts)));
    end

endmodule

// File: tb/tb_csr_req_router.sv
// Directed bench for csr_req_router: routing, in-order read return, FIFO
// backpressure, unmapped windows, pointer wrap and mid-flight reset.
module tb_csr_req_router;
    localparam int NP = 2;
    localparam int RPP = 8;
    localparam int DW = 32;
    localparam int MO = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] outstanding;
    int         n_tests = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    csr_req_router_if #(.NumPorts(NP), .RegsPerPort(RPP), .RegDataWidth(DW)) bus ();

    csr_req_router #(
        .NumPorts(NP), .RegsPerPort(RPP), .RegDataWidth(DW), .MaxOutstanding(MO)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .bus           (bus),
        .outstanding_o (outstanding)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.csr_req_addr_i      = '0;
        bus.csr_req_data_i      = '0;
        bus.csr_req_wen_i       = 1'b0;
        bus.csr_req_valid_i     = 1'b0;
        bus.csr_rsp_ready_i     = 1'b0;
        bus.acc_csr_rsp_data_i  = '0;
        bus.acc_csr_rsp_valid_i = '0;
    endtask

    task automatic req(input logic [4:0] a, input logic [31:0] d, input logic w);
        bus.csr_req_addr_i  = a;
        bus.csr_req_data_i  = d;
        bus.csr_req_wen_i   = w;
        bus.csr_req_valid_i = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        bus.acc_csr_req_ready_i = '1;
        req(5'd0, 32'h0, 1'b0);
        bus.acc_csr_rsp_valid_i = '1;
        bus.csr_rsp_ready_i = 1'b1;
        tick();
        tick();
        n_tests++; if (bus.csr_req_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0", bus.csr_req_ready_o); end
        n_tests++; if (bus.acc_csr_req_valid_o !== 2'b00) begin n_fail++; $display("FAIL reset_acc_valid: got %b want 00", bus.acc_csr_req_valid_o); end
        n_tests++; if (bus.csr_rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", bus.csr_rsp_valid_o); end
        n_tests++; if (bus.acc_csr_rsp_ready_o !== 2'b00) begin n_fail++; $display("FAIL reset_acc_rsp_ready: got %b want 00", bus.acc_csr_rsp_ready_o); end
        rst_n = 1'b1;
        idle();
        tick();
        n_tests++; if (outstanding !== 2'd0) begin n_fail++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
    endtask

    task automatic test_write();
        idle();
        bus.acc_csr_req_ready_i = 2'b10;
        req(5'd10, 32'hA5A5A5A5, 1'b1);
        #1;
        n_tests++; if (bus.acc_csr_req_valid_o !== 2'b10) begin n_fail++; $display("FAIL wr_acc_valid: got %b want 10", bus.acc_csr_req_valid_o); end
        n_tests++; if (bus.acc_csr_req_addr_o[1] !== 3'd2) begin n_fail++; $display("FAIL wr_addr: got %0d want 2", bus.acc_csr_req_addr_o[1]); end
        n_tests++; if (bus.acc_csr_req_data_o[1] !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL wr_data: got %h want a5a5a5a5", bus.acc_csr_req_data_o[1]); end
        n_tests++; if (bus.acc_csr_req_wen_o !== 2'b10) begin n_fail++; $display("FAIL wr_wen: got %b want 10", bus.acc_csr_req_wen_o); end
        n_tests++; if (bus.acc_csr_req_data_o[0] !== 32'h0) begin n_fail++; $display("FAIL wr_port0_data: got %h want 0", bus.acc_csr_req_data_o[0]); end
        n_tests++; if (bus.csr_req_ready_o !== 1'b1) begin n_fail++; $display("FAIL wr_ready: got %b want 1", bus.csr_req_ready_o); end
        bus.acc_csr_req_ready_i = 2'b01;
        #1;
        n_tests++; if (bus.csr_req_ready_o !== 1'b0) begin n_fail++; $display("FAIL wr_ready_follows_port: got %b want 0", bus.csr_req_ready_o); end
        bus.acc_csr_req_ready_i = 2'b10;
        tick();
        idle();
        #1;
        n_tests++; if (outstanding !== 2'd0) begin n_fail++; $display("FAIL wr_outstanding: got %0d want 0", outstanding); end
        n_tests++; if (bus.csr_rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL wr_no_rsp: got %b want 0", bus.csr_rsp_valid_o); end
    endtask

    task automatic test_ordering();
        idle();
        bus.acc_csr_req_ready_i = 2'b11;
        req(5'd3, 32'h0, 1'b0);
        #1;
        n_tests++; if (bus.acc_csr_req_valid_o !== 2'b01) begin n_fail++; $display("FAIL ord_rd0_valid: got %b want 01", bus.acc_csr_req_valid_o); end
        n_tests++; if (bus.acc_csr_req_addr_o[0] !== 3'd3) begin n_fail++; $display("FAIL ord_rd0_addr: got %0d want 3", bus.acc_csr_req_addr_o[0]); end
        tick();
        req(5'd9, 32'h0, 1'b0);
        #1;
        n_tests++; if (bus.acc_csr_req_addr_o[1] !== 3'd1) begin n_fail++; $display("FAIL ord_rd1_addr: got %0d want 1", bus.acc_csr_req_addr_o[1]); end
        tick();
        idle();
        bus.csr_rsp_ready_i = 1'b1;
        bus.acc_csr_rsp_valid_i = 2'b10;
        bus.acc_csr_rsp_data_i[1] = 32'h22;
        #1;
        n_tests++; if (outstanding !== 2'd2) begin n_fail++; $display("FAIL ord_outstanding: got %0d want 2", outstanding); end
        n_tests++; if (bus.csr_rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL ord_stall_valid: got %b want 0", bus.csr_rsp_valid_o); end
        n_tests++; if (bus.acc_csr_rsp_ready_o !== 2'b01) begin n_fail++; $display("FAIL ord_stall_ready: got %b want 01", bus.acc_csr_rsp_ready_o); end
        tick();
        tick();
        bus.acc_csr_rsp_valid_i = 2'b11;
        bus.acc_csr_rsp_data_i[0] = 32'h11;
        #1;
        n_tests++; if (bus.csr_rsp_data_o !== 32'h11 || bus.csr_rsp_valid_o !== 1'b1) begin n_fail++; $display("FAIL ord_first_rsp: got %b/%h want 1/11", bus.csr_rsp_valid_o, bus.csr_rsp_data_o); end
        n_tests++; if (bus.acc_csr_rsp_ready_o !== 2'b01) begin n_fail++; $display("FAIL ord_first_ready: got %b want 01", bus.acc_csr_rsp_ready_o); end
        tick();
        bus.acc_csr_rsp_valid_i = 2'b10;
        #1;
        n_tests++; if (bus.csr_rsp_data_o !== 32'h22 || bus.csr_rsp_valid_o !== 1'b1) begin n_fail++; $display("FAIL ord_second_rsp: got %b/%h want 1/22", bus.csr_rsp_valid_o, bus.csr_rsp_data_o); end
        n_tests++; if (bus.acc_csr_rsp_ready_o !== 2'b10) begin n_fail++; $display("FAIL ord_second_ready: got %b want 10", bus.acc_csr_rsp_ready_o); end
        tick();
        idle();
        #1;
        n_tests++; if (outstanding !== 2'd0) begin n_fail++; $display("FAIL ord_drained: got %0d want 0", outstanding); end
    endtask

    task automatic test_full();
        idle();
        bus.acc_csr_req_ready_i = 2'b11;
        req(5'd0, 32'h0, 1'b0);
        tick();
        req(5'd8, 32'h0, 1'b0);
        tick();
        req(5'd1, 32'h0, 1'b0);
        #1;
        n_tests++; if (bus.csr_req_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0", bus.csr_req_ready_o); end
        n_tests++; if (outstanding !== 2'd2) begin n_fail++; $display("FAIL full_outstanding: got %0d want 2", outstanding); end
        tick();
        bus.acc_csr_rsp_valid_i = 2'b01;
        bus.acc_csr_rsp_data_i[0] = 32'h33;
        bus.csr_rsp_ready_i = 1'b1;
        #1;
        n_tests++; if (bus.csr_rsp_data_o !== 32'h33) begin n_fail++; $display("FAIL full_pop_data: got %h want 33", bus.csr_rsp_data_o); end
        n_tests++; if (bus.csr_req_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_no_bypass: got %b want 0", bus.csr_req_ready_o); end
        tick();
        bus.acc_csr_rsp_valid_i = 2'b00;
        bus.csr_rsp_ready_i = 1'b0;
        #1;
        n_tests++; if (outstanding !== 2'd1) begin n_fail++; $display("FAIL full_after_pop: got %0d want 1", outstanding); end
        n_tests++; if (bus.csr_req_ready_o !== 1'b1) begin n_fail++; $display("FAIL full_accept_next: got %b want 1", bus.csr_req_ready_o); end
        tick();
        idle();
        #1;
        n_tests++; if (outstanding !== 2'd2) begin n_fail++; $display("FAIL full_refill: got %0d want 2", outstanding); end
        bus.csr_rsp_ready_i = 1'b1;
        bus.acc_csr_rsp_valid_i = 2'b10;
        bus.acc_csr_rsp_data_i[1] = 32'h44;
        #1;
        n_tests++; if (bus.csr_rsp_data_o !== 32'h44) begin n_fail++; $display("FAIL full_drain1: got %h want 44", bus.csr_rsp_data_o); end
        tick();
        bus.acc_csr_rsp_valid_i = 2'b01;
        bus.acc_csr_rsp_data_i[0] = 32'h55;
        #1;
        n_tests++; if (bus.csr_rsp_data_o !== 32'h55) begin n_fail++; $display("FAIL full_drain2: got %h want 55", bus.csr_rsp_data_o); end
        tick();
        idle();
        #1;
        n_tests++; if (outstanding !== 2'd0) begin n_fail++; $display("FAIL full_drained: got %0d want 0", outstanding); end
    endtask

    task automatic test_unmapped();
        idle();
        bus.acc_csr_req_ready_i = 2'b11;
        req(5'd20, 32'h0, 1'b0);
        #1;
        n_tests++; if (bus.csr_req_ready_o !== 1'b1) begin n_fail++; $display("FAIL unm_rd_ready: got %b want 1", bus.csr_req_ready_o); end
        n_tests++; if (bus.acc_csr_req_valid_o !== 2'b00) begin n_fail++; $display("FAIL unm_rd_acc_valid: got %b want 00", bus.acc_csr_req_valid_o); end
        tick();
        idle();
        #1;
        n_tests++; if (bus.csr_rsp_valid_o !== 1'b1 || bus.csr_rsp_data_o !== 32'h0) begin n_fail++; $display("FAIL unm_rsp: got %b/%h want 1/0", bus.csr_rsp_valid_o, bus.csr_rsp_data_o); end
        n_tests++; if (bus.acc_csr_rsp_ready_o !== 2'b00) begin n_fail++; $display("FAIL unm_acc_rsp_ready: got %b want 00", bus.acc_csr_rsp_ready_o); end
        bus.csr_rsp_ready_i = 1'b1;
        tick();
        idle();
        bus.acc_csr_req_ready_i = 2'b00;
        req(5'd20, 32'hDEAD, 1'b1);
        #1;
        n_tests++; if (bus.csr_req_ready_o !== 1'b1 || bus.acc_csr_req_valid_o !== 2'b00) begin n_fail++; $display("FAIL unm_wr: got rdy %b acc %b want 1/00", bus.csr_req_ready_o, bus.acc_csr_req_valid_o); end
        tick();
        idle();
        #1;
        n_tests++; if (outstanding !== 2'd0 || bus.csr_rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL unm_wr_no_rsp: got out %0d vld %b want 0/0", outstanding, bus.csr_rsp_valid_o); end
    endtask

    task automatic test_wrap();
        idle();
        bus.acc_csr_req_ready_i = 2'b11;
        req(5'd0, 32'h0, 1'b0);
        tick();
        for (int i = 1; i < 10; i++) begin
            int p;
            p = (i - 1) % 2;
            req(5'((i % 2) * 8 + (i % 8)), 32'h0, 1'b0);
            bus.acc_csr_rsp_valid_i = '0;
            bus.acc_csr_rsp_valid_i[p] = 1'b1;
            bus.acc_csr_rsp_data_i[p] = 32'h100 + 32'(i - 1);
            bus.csr_rsp_ready_i = 1'b1;
            #1;
            n_tests++; if (bus.csr_rsp_valid_o !== 1'b1 || bus.csr_rsp_data_o !== 32'h100 + 32'(i - 1)) begin n_fail++; $display("FAIL wrap_rsp[%0d]: got %b/%h want 1/%h", i, bus.csr_rsp_valid_o, bus.csr_rsp_data_o, 32'h100 + 32'(i - 1)); end
            n_tests++; if (bus.csr_req_ready_o !== 1'b1) begin n_fail++; $display("FAIL wrap_ready[%0d]: got %b want 1", i, bus.csr_req_ready_o); end
            tick();
            n_tests++; if (outstanding !== 2'd1) begin n_fail++; $display("FAIL wrap_outstanding[%0d]: got %0d want 1", i, outstanding); end
        end
        idle();
        bus.acc_csr_rsp_valid_i = 2'b10;
        bus.acc_csr_rsp_data_i[1] = 32'h109;
        bus.csr_rsp_ready_i = 1'b1;
        #1;
        n_tests++; if (bus.csr_rsp_data_o !== 32'h109) begin n_fail++; $display("FAIL wrap_last: got %h want 109", bus.csr_rsp_data_o); end
        tick();
        idle();
        #1;
        n_tests++; if (outstanding !== 2'd0) begin n_fail++; $display("FAIL wrap_drained: got %0d want 0", outstanding); end
    endtask

    task automatic test_reset_mid();
        idle();
        bus.acc_csr_req_ready_i = 2'b11;
        req(5'd2, 32'h0, 1'b0);
        tick();
        req(5'd11, 32'h0, 1'b0);
        tick();
        idle();
        #1;
        n_tests++; if (outstanding !== 2'd2) begin n_fail++; $display("FAIL rmid_pre: got %0d want 2", outstanding); end
        rst_n = 1'b0;
        bus.csr_rsp_ready_i = 1'b1;
        bus.acc_csr_rsp_valid_i = 2'b11;
        tick();
        rst_n = 1'b1;
        #1;
        n_tests++; if (outstanding !== 2'd0) begin n_fail++; $display("FAIL rmid_outstanding: got %0d want 0", outstanding); end
        n_tests++; if (bus.csr_rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL rmid_rsp_valid: got %b want 0", bus.csr_rsp_valid_o); end
        n_tests++; if (bus.acc_csr_rsp_ready_o !== 2'b00) begin n_fail++; $display("FAIL rmid_acc_rsp_ready: got %b want 00", bus.acc_csr_rsp_ready_o); end
        idle();
        req(5'd5, 32'h0, 1'b0);
        #1;
        n_tests++; if (bus.csr_req_ready_o !== 1'b1) begin n_fail++; $display("FAIL rmid_new_ready: got %b want 1", bus.csr_req_ready_o); end
        tick();
        idle();
        bus.acc_csr_rsp_valid_i = 2'b01;
        bus.acc_csr_rsp_data_i[0] = 32'h77;
        bus.csr_rsp_ready_i = 1'b1;
        #1;
        n_tests++; if (bus.csr_rsp_valid_o !== 1'b1 || bus.csr_rsp_data_o !== 32'h77) begin n_fail++; $display("FAIL rmid_new_rsp: got %b/%h want 1/77", bus.csr_rsp_valid_o, bus.csr_rsp_data_o); end
        n_tests++; if (bus.acc_csr_rsp_ready_o !== 2'b01) begin n_fail++; $display("FAIL rmid_new_ready_o: got %b want 01", bus.acc_csr_rsp_ready_o); end
        tick();
        idle();
        #1;
        n_tests++; if (outstanding !== 2'd0) begin n_fail++; $display("FAIL rmid_drained: got %0d want 0", outstanding); end
    endtask

    initial begin
        bus.acc_csr_req_ready_i = '0;
        idle();
        test_reset();
        test_write();
        test_ordering();
        test_full();
        test_unmapped();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
